// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int unsigned PC_INC    = 4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/ready port; master is the fetch stage, slave is the memory.
interface instr_fetch_if #(
  parameter int PC_WIDTH    = 64,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ready;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/instr_fetch_pc_reg.sv
// Program counter: reset value, word-aligned redirect load, +4 advance on capture.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                inc,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target & ~PC_WIDTH'(3);
    end else if (inc) begin
      pc <= pc + PC_WIDTH'(PC_INC);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the imem request port and the registered IF/ID output slot.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH    = 64,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   PC_Write,
  input  logic                   Branch_Taken,
  input  logic [PC_WIDTH-1:0]    Branch_Target,
  instr_fetch_if.master          imem,
  output logic [INSTR_WIDTH-1:0] Instruction,
  output logic [PC_WIDTH-1:0]    PC_Out,
  output logic                   Fetch_Valid
);

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc, req_addr, req_addr_nxt, fetch_addr;
  logic                fetch_req, slot_ok, capture;

  fetch_pc_reg #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .reset  (reset),
    .load   (Branch_Taken),
    .inc    (capture),
    .target (Branch_Target),
    .pc     (pc)
  );

  always_comb begin
    slot_ok      = !Fetch_Valid || PC_Write;
    state_nxt    = state;
    req_addr_nxt = req_addr;
    fetch_req    = 1'b0;
    fetch_addr   = pc;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        fetch_req = slot_ok;
        if (fetch_req && !imem.imem_ready) begin
          // A redirect here still leaves a live request that must be drained.
          state_nxt    = Branch_Taken ? DRAIN : WAIT;
          req_addr_nxt = pc;
        end else if (fetch_req) begin
          capture = !Branch_Taken;
        end
      end
      WAIT: begin
        fetch_req  = 1'b1;
        fetch_addr = req_addr;
        if (imem.imem_ready) begin
          state_nxt = IDLE;
          capture   = !Branch_Taken;
        end else if (Branch_Taken) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        fetch_req  = 1'b1;
        fetch_addr = req_addr;
        if (imem.imem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!reset) fetch_req = 1'b0;
  end

  assign imem.imem_req  = fetch_req;
  assign imem.imem_addr = fetch_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      req_addr    <= '0;
      Fetch_Valid <= 1'b0;
      Instruction <= INSTR_WIDTH'(INSTR_NOP);
      PC_Out      <= '0;
    end else begin
      state    <= state_nxt;
      req_addr <= req_addr_nxt;
      if (Branch_Taken) begin
        Fetch_Valid <= 1'b0;
      end else if (capture) begin
        Fetch_Valid <= 1'b1;
        Instruction <= imem.imem_rdata;
        PC_Out      <= fetch_addr;
      end else if (PC_Write) begin
        Fetch_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and random stimulus for instr_fetch against an outstanding-transaction reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset, PC_Write, Branch_Taken;
  logic [63:0] Branch_Target;
  logic [31:0] Instruction;
  logic [63:0] PC_Out;
  logic        Fetch_Valid;
  int          tests = 0;
  int          fails = 0;

  instr_fetch_if #(.PC_WIDTH(64), .INSTR_WIDTH(32)) bus ();

  instr_fetch #(.PC_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(64'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .PC_Write      (PC_Write),
    .Branch_Taken  (Branch_Taken),
    .Branch_Target (Branch_Target),
    .imem          (bus.master),
    .Instruction   (Instruction),
    .PC_Out        (PC_Out),
    .Fetch_Valid   (Fetch_Valid)
  );

  always #5 clk = ~clk;

  // Reference model: one optional outstanding request, flagged stale once a redirect passes it.
  logic [63:0] m_pc, m_paddr, m_pcout;
  logic        m_pend, m_stale, m_fv;
  logic [31:0] m_instr;
  logic        e_req;
  logic [63:0] e_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic pw, input logic bt, input logic [63:0] tgt,
                     input logic rdy, input logic [31:0] rd);
    logic acc;
    reset = r; PC_Write = pw; Branch_Taken = bt; Branch_Target = tgt;
    bus.imem_ready = rdy; bus.imem_rdata = rd;
    #1;
    e_req  = r && (m_pend || !m_fv || pw);
    e_addr = m_pend ? m_paddr : m_pc;
    chk("imem_req", {63'd0, bus.imem_req}, {63'd0, e_req});
    if (e_req) chk("imem_addr", bus.imem_addr, e_addr);
    @(posedge clk);
    acc = e_req && rdy;
    if (!r) begin
      m_pc = 64'h0; m_pend = 0; m_stale = 0; m_paddr = 0;
      m_fv = 0; m_instr = 0; m_pcout = 0;
    end else if (bt) begin
      m_fv = 0;
      m_pc = {tgt[63:2], 2'b00};
      if (acc) m_pend = 0;
      else if (e_req) begin m_pend = 1; m_paddr = e_addr; m_stale = 1; end
    end else if (acc && !(m_pend && m_stale)) begin
      m_fv = 1; m_instr = rd; m_pcout = e_addr; m_pc = m_pc + 64'd4; m_pend = 0;
    end else begin
      if (acc) m_pend = 0;
      else if (e_req && !m_pend) begin m_pend = 1; m_paddr = e_addr; m_stale = 0; end
      if (pw) m_fv = 0;
    end
    #1;
    chk("Fetch_Valid", {63'd0, Fetch_Valid}, {63'd0, m_fv});
    chk("PC_Out", PC_Out, m_pcout);
    chk("Instruction", {32'd0, Instruction}, {32'd0, m_instr});
  endtask

  initial begin
    reset = 0; PC_Write = 1; Branch_Taken = 0; Branch_Target = 0;
    bus.imem_ready = 1; bus.imem_rdata = 0;
    m_pc = 0; m_pend = 0; m_stale = 0; m_paddr = 0; m_fv = 0; m_instr = 0; m_pcout = 0;
    e_req = 0; e_addr = 0;
    @(posedge clk); #1;

    // Reset held with memory ready: no request, outputs cleared.
    repeat (3) cyc(0, 1, 0, 0, 1, 32'h13);
    chk("reset Fetch_Valid", {63'd0, Fetch_Valid}, 64'd0);

    // Zero-wait streaming from address 0.
    cyc(1, 1, 0, 0, 1, 32'h13);
    chk("first PC_Out", PC_Out, 64'h0);
    cyc(1, 1, 0, 0, 1, 32'h13);
    chk("stream PC_Out 4", PC_Out, 64'h4);
    cyc(1, 1, 0, 0, 1, 32'h13);
    chk("stream PC_Out 8", PC_Out, 64'h8);
    cyc(1, 1, 0, 0, 1, 32'h13);
    chk("stream PC_Out 12", PC_Out, 64'hC);

    // Three wait states on the fetch at 0x10, captured on the fourth edge.
    repeat (3) cyc(1, 1, 0, 0, 0, 32'h0);
    cyc(1, 1, 0, 0, 1, 32'hA5A5_0001);
    chk("wait capture PC_Out", PC_Out, 64'h10);

    // Stall with a valid slot: outputs hold, no request.
    repeat (2) cyc(1, 0, 0, 0, 1, 32'h1111_1111);
    chk("stall hold PC_Out", PC_Out, 64'h10);
    cyc(1, 1, 0, 0, 1, 32'h2222_2222);
    chk("resume PC_Out", PC_Out, 64'h14);

    // Redirect while a request is pending; late data must be dropped.
    cyc(1, 1, 0, 0, 0, 32'h0);
    cyc(1, 1, 1, 64'h100, 0, 32'h0);
    cyc(1, 1, 0, 0, 0, 32'h0);
    cyc(1, 1, 0, 0, 1, 32'hDEAD_BEEF);
    chk("drained Fetch_Valid", {63'd0, Fetch_Valid}, 64'd0);
    cyc(1, 1, 0, 0, 1, 32'h3333_3333);
    chk("post-drain PC_Out", PC_Out, 64'h100);

    // Misaligned target is aligned down.
    cyc(1, 1, 1, 64'h203, 1, 32'h0);
    cyc(1, 1, 0, 0, 1, 32'h4444_4444);
    chk("aligned PC_Out", PC_Out, 64'h200);

    // PC wraps from the top word to zero.
    cyc(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'h0);
    cyc(1, 1, 0, 0, 1, 32'h5555_5555);
    chk("top PC_Out", PC_Out, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(1, 1, 0, 0, 1, 32'h6666_6666);
    chk("wrapped PC_Out", PC_Out, 64'h0);

    // Redirect during a stall still clears the slot.
    cyc(1, 0, 1, 64'h300, 1, 32'h0);
    chk("stall redirect Fetch_Valid", {63'd0, Fetch_Valid}, 64'd0);
    cyc(1, 1, 0, 0, 1, 32'h7777_7777);
    chk("stall redirect PC_Out", PC_Out, 64'h300);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 9) == 0), {$urandom, $urandom},
          ($urandom_range(0, 1) == 1), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
